// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: splits one vector op into LANES element memory
// transactions. Define VSEQ_STRIDE_EN to add a runtime signed byte-stride port.
module vector_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    load_vector,
    input  logic                    store_vector,
    input  logic [ADDR_W-1:0]       base_addr,
`ifdef VSEQ_STRIDE_EN
    input  logic [ADDR_W-1:0]       stride,
`endif
    input  logic [LANES*DATA_W-1:0] vstore_data,
    output logic                    stall,
    output logic                    busy,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    vreg_we,
    output logic [LANES*DATA_W-1:0] vreg_wdata,
    output logic                    done,
    output logic                    op_err
);

    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    is_store_q, is_store_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LANES*DATA_W-1:0] wvec_q, wvec_d;
    logic [LANES*DATA_W-1:0] buf_q, buf_d;
    logic [ADDR_W-1:0]       step;

`ifdef VSEQ_STRIDE_EN
    logic [ADDR_W-1:0]       stride_q, stride_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
        end else begin
            stride_q <= stride_d;
        end
    end

    always_comb begin
        stride_d = stride_q;
        if (state_q == S_IDLE && !rst && issue_valid && (load_vector ^ store_vector)) begin
            stride_d = stride;
        end
    end

    assign step = stride_q;
`else
    assign step = ADDR_W'(4);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            wvec_q     <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            wvec_q     <= wvec_d;
            buf_q      <= buf_d;
        end
    end

    // Address advances by accumulation and store data by shifting, so the
    // current element is always at addr_q / wvec_q[DATA_W-1:0].
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        wvec_d     = wvec_q;
        buf_d      = buf_q;
        stall      = 1'b0;
        busy       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        vreg_we    = 1'b0;
        vreg_wdata = '0;
        done       = 1'b0;
        op_err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rst && issue_valid) begin
                    if (load_vector && store_vector) begin
                        op_err = 1'b1;
                    end else if (load_vector || store_vector) begin
                        stall      = 1'b1;
                        state_d    = S_REQ;
                        is_store_d = store_vector;
                        addr_d     = base_addr;
                        wvec_d     = vstore_data;
                        buf_d      = '0;
                        idx_d      = '0;
                    end
                end
            end

            S_REQ: begin
                busy      = 1'b1;
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = is_store_q;
                mem_addr  = addr_q;
                mem_wdata = wvec_q[DATA_W-1:0];
                if (mem_ack) begin
                    if (!is_store_q) begin
                        buf_d[idx_q*DATA_W +: DATA_W] = mem_rdata;
                    end
                    wvec_d = wvec_q >> DATA_W;
                    addr_d = addr_q + step;
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        state_d = S_WB;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_WB: begin
                busy    = 1'b1;
                done    = 1'b1;
                vreg_we = !is_store_q;
                if (!is_store_q) begin
                    vreg_wdata = buf_q;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer; expected addresses, data and
// timing come from a lane-by-lane model of the op. Honours VSEQ_STRIDE_EN.
module tb_vector_mem_sequencer;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int VW     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid, load_vector, store_vector;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride_v;
    logic [VW-1:0]     vstore_data;
    logic              stall, busy, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              vreg_we;
    logic [VW-1:0]     vreg_wdata;
    logic              done, op_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .load_vector (load_vector),
        .store_vector(store_vector),
        .base_addr   (base_addr),
`ifdef VSEQ_STRIDE_EN
        .stride      (stride_v),
`endif
        .vstore_data (vstore_data),
        .stall       (stall),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .vreg_we     (vreg_we),
        .vreg_wdata  (vreg_wdata),
        .done        (done),
        .op_err      (op_err)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        load_vector  = 1'b0;
        store_vector = 1'b0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_req"}, mem_req, 1'b0);
        chk({tag, "_addr"}, mem_addr, '0);
        chk({tag, "_vwe"}, vreg_we, 1'b0);
        chk({tag, "_vwd"}, vreg_wdata, '0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, op_err, 1'b0);
    endtask

    // One full op: element i lives at base + i*strd, takes a random number of
    // wait cycles in [wlo,whi] before its ack; loads collect the acked rdata.
    task automatic run_op(input bit is_st, input logic [ADDR_W-1:0] base,
                          input logic [ADDR_W-1:0] strd, input logic [VW-1:0] vdata,
                          input int wlo, input int whi, input bit fixed_rd);
        logic [VW-1:0]     exp_vec;
        logic [ADDR_W-1:0] a;
        int                w;
        exp_vec = '0;
        @(negedge clk);
        issue_valid  = 1'b1;
        load_vector  = !is_st;
        store_vector = is_st;
        base_addr    = base;
        stride_v     = strd;
        vstore_data  = vdata;
        #1;
        chk("acc_stall", stall, 1'b1);
        chk("acc_busy", busy, 1'b0);
        chk("acc_req", mem_req, 1'b0);
        for (int i = 0; i < LANES; i++) begin
            a = base + ADDR_W'(i) * strd;
            w = $urandom_range(whi, wlo);
            for (int k = 0; k <= w; k++) begin
                @(negedge clk);
                issue_valid  = 1'($urandom);
                load_vector  = 1'($urandom);
                store_vector = 1'($urandom);
                base_addr    = $urandom;
                stride_v     = $urandom;
                vstore_data  = {$urandom, $urandom, $urandom, $urandom};
                mem_ack      = (k == w);
                mem_rdata    = fixed_rd ? DATA_W'(32'hA0 + i) : $urandom;
                if (k == w && !is_st) exp_vec[i*DATA_W +: DATA_W] = mem_rdata;
                #1;
                chk("req_valid", mem_req, 1'b1);
                chk("req_we", mem_we, is_st);
                chk("req_addr", mem_addr, a);
                chk("req_stall", stall, 1'b1);
                chk("req_busy", busy, 1'b1);
                chk("req_done", done, 1'b0);
                chk("req_vwe", vreg_we, 1'b0);
                if (is_st) chk("req_wdata", mem_wdata, vdata[i*DATA_W +: DATA_W]);
            end
        end
        @(negedge clk);
        issue_valid  = 1'b1;
        load_vector  = 1'b1;
        store_vector = 1'b0;
        mem_ack      = 1'($urandom);
        mem_rdata    = $urandom;
        #1;
        chk("wb_done", done, 1'b1);
        chk("wb_stall", stall, 1'b0);
        chk("wb_req", mem_req, 1'b0);
        chk("wb_vwe", vreg_we, !is_st);
        chk("wb_vwdata", vreg_wdata, is_st ? '0 : exp_vec);
        @(negedge clk);
        idle_inputs();
        #1;
        chk_quiet("post");
    endtask

    initial begin
        logic [VW-1:0] v;
        rst = 1'b1;
        idle_inputs();
        base_addr   = '0;
        stride_v    = 32'd4;
        vstore_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("rst_rel");

        // Zero-wait load, rdata 0xA0+idx
        v = {$urandom, $urandom, $urandom, $urandom};
        run_op(1'b0, 32'h100, 32'd4, v, 0, 0, 1'b1);

        // Store with exactly two wait cycles per element
        v = {32'd4, 32'd3, 32'd2, 32'd1};
        run_op(1'b1, 32'h2000, 32'd4, v, 2, 2, 1'b0);

        // Both decoder flags set
        @(negedge clk);
        issue_valid  = 1'b1;
        load_vector  = 1'b1;
        store_vector = 1'b1;
        #1;
        chk("both_err", op_err, 1'b1);
        chk("both_stall", stall, 1'b0);
        chk("both_req", mem_req, 1'b0);
        chk("both_busy", busy, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk_quiet("both_after");

        // Reset after second ack of a load
        @(negedge clk);
        issue_valid = 1'b1;
        load_vector = 1'b1;
        base_addr   = 32'h500;
        stride_v    = 32'd4;
        @(negedge clk);
        idle_inputs();
        mem_ack   = 1'b1;
        mem_rdata = 32'h11;
        @(negedge clk);
        mem_rdata = 32'h22;
        #1;
        chk("abort_addr1", mem_addr, 32'h504);
        @(negedge clk);
        mem_ack = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("abort");
        v = {$urandom, $urandom, $urandom, $urandom};
        run_op(1'b0, 32'h600, 32'd4, v, 0, 1, 1'b0);

        // Address wrap-around
        run_op(1'b0, 32'hFFFF_FFF8, 32'd4, v, 0, 0, 1'b0);

        // Randomized ops
        for (int n = 0; n < 8; n++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            run_op(1'($urandom), $urandom, 32'd4, v, 0, 3, 1'b0);
        end

`ifdef VSEQ_STRIDE_EN
        run_op(1'b0, 32'h40, 32'hFFFF_FFF8, v, 0, 0, 1'b0);
        run_op(1'b1, $urandom, $urandom, v, 0, 2, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
